packet_echo_responder: RTL and testbench
========================================

PACKET_ECHO_RESPONDER -- requirements
Module: packet_echo_responder

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 15: bytes per packet, legal range 1..255.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 104: clk cycles per UART bit, minimum 4, even.
REQ-003 SHALL have parameter GAP_BITS, default 20: inter-byte timeout, in bit-times.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port rxd  input  1  asynchronous UART serial input; idle level is high.
REQ-007 SHALL have port txd  output  1  UART serial output, 8N1, LSB first.
REQ-008 SHALL have port busy  output  1  high while the response packet is being transmitted.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port pkt_count  output  16  count of packets fully echoed; wraps 0xFFFF->0.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer before any use; latency is counted from the synchronized signal.
REQ-012 SHALL implement the FSM IDLE, START, DATA, STOP, RESPOND, TX_START, TX_DATA, TX_STOP.
REQ-013 IDLE: a high-to-low transition on synchronized rxd SHALL enter START and clear the bit timer.
REQ-014 START: after CLKS_PER_BIT/2 cycles, a low sample SHALL enter DATA and a high sample (glitch) SHALL return to IDLE with no state change elsewhere.
REQ-015 DATA: SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, shifted LSB first.
REQ-016 STOP: a sample CLKS_PER_BIT cycles after the last data bit SHALL store the byte at index byte_idx if high; if low, SHALL pulse frame_err, discard the partial packet (byte_idx<=0) and return to IDLE.
REQ-017 After a good stop bit, if byte_idx==PACKET_SIZE-1 SHALL enter RESPOND, else SHALL increment byte_idx and return to IDLE.
REQ-018 While byte_idx!=0 in IDLE, GAP_BITS*CLKS_PER_BIT cycles without a start edge SHALL discard the partial packet (byte_idx<=0), with no frame_err pulse.
REQ-019 RESPOND SHALL last one cycle, assert busy, and reset tx_idx to 0.
REQ-020 TX SHALL send buffer[0] through buffer[PACKET_SIZE-1] in receive order; each byte is 1 low start bit, 8 data bits LSB first, and 1 high stop bit, each held exactly CLKS_PER_BIT cycles.
REQ-021 Bytes SHALL be sent back to back, with no idle bits between one stop bit and the next start bit.
REQ-022 At the end of the last stop bit SHALL deassert busy, increment pkt_count, and return to IDLE in the same cycle.
REQ-023 While busy, rxd SHALL be ignored; edges on rxd during TX SHALL NOT start reception after TX ends unless a new falling edge occurs in IDLE.
REQ-024 txd SHALL be high in every state except TX_START, TX_DATA and TX_STOP.
REQ-025 Buffer storage SHALL be PACKET_SIZE x 8 bits; byte_idx and tx_idx widths SHALL be the clog2 of PACKET_SIZE, minimum 1.

Reset
REQ-026 rst high SHALL immediately force: state=IDLE, txd=1, busy=0, frame_err=0, pkt_count=0, byte_idx=0, tx_idx=0, bit timers=0, synchronizer flops=1.
REQ-027 Buffer contents SHALL NOT require reset.
REQ-028 Reset asserted mid-reception or mid-transmission SHALL abort the packet; after release, txd SHALL remain high until a complete new packet has been received.

Verification (PACKET_SIZE=3, CLKS_PER_BIT=4, GAP_BITS=20)
REQ-029 Send 0x41,0x42,0x43 as 8N1 -> txd emits 0x41,0x42,0x43 back to back (30 bit-times, 120 cycles); busy high throughout; pkt_count=1.
REQ-030 Send 0x41 followed by a byte whose stop bit is low -> one frame_err pulse; then 0x01,0x02,0x03 -> echo of 0x01,0x02,0x03 only.
REQ-031 Send a low glitch 1 cycle wide on idle rxd -> no reception, txd stays 1, frame_err=0.
REQ-032 Send 0x55,0xAA, idle 81 cycles, then 0x10,0x20,0x30 -> echo of 0x10,0x20,0x30 only.
REQ-033 Send 0xFF,0x00,0x7E and toggle rxd during the echo -> echo unaffected; no extra reception after busy falls.
REQ-034 Assert rst during the second echoed byte -> txd=1 and busy=0 immediately; pkt_count=0; no further output until a new packet is received.

Source files
------------

// File: rtl/packet_echo_responder.sv
// UART packet echo: receives PACKET_SIZE 8N1 bytes on rxd, then replays them
// back to back on txd. Partial packets are dropped on a framing error or gap timeout.
module packet_echo_responder #(
    parameter int unsigned PACKET_SIZE  = 15,
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned GAP_BITS     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] pkt_count
);

    localparam int unsigned IDX_W      = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int unsigned TMR_W      = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACKET_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP,
        S_RESPOND, S_TX_START, S_TX_DATA, S_TX_STOP
    } state_t;

    state_t           state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TMR_W-1:0] tmr_q;
    logic [GAP_W-1:0] gap_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       rx_shift_q, tx_shift_q;
    logic [IDX_W-1:0] byte_idx_q, tx_idx_q;
    logic             txd_q, busy_q, frame_err_q;
    logic [15:0]      pkt_count_q;
    logic [7:0]       buf_q [PACKET_SIZE];

    logic             buf_we_c;
    logic [7:0]       tx_byte_c;

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign pkt_count = pkt_count_q;

    assign buf_we_c  = (state_q == S_STOP) && (tmr_q == TMR_LAST) && rx_sync_q;
    assign tx_byte_c = buf_q[tx_idx_q];

    // Packet buffer carries no reset; it is always written before it is replayed.
    always_ff @(posedge clk) begin
        if (buf_we_c) begin
            buf_q[byte_idx_q] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            tmr_q       <= '0;
            gap_q       <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            byte_idx_q  <= '0;
            tx_idx_q    <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            rx_meta_q   <= rxd;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            frame_err_q <= 1'b0;
            tmr_q       <= tmr_q + TMR_W'(1);
            gap_q       <= '0;

            case (state_q)
                S_IDLE: begin
                    tmr_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= S_START;
                    end else if (byte_idx_q != '0) begin
                        // Inter-byte timeout drops a stalled partial packet
                        if (gap_q == GAP_LAST) begin
                            byte_idx_q <= '0;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                end
                S_START: begin
                    if (tmr_q == TMR_HALF) begin
                        tmr_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_sync_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tmr_q == TMR_LAST) begin
                        tmr_q      <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tmr_q == TMR_LAST) begin
                        tmr_q <= '0;
                        if (!rx_sync_q) begin
                            frame_err_q <= 1'b1;
                            byte_idx_q  <= '0;
                            state_q     <= S_IDLE;
                        end else if (byte_idx_q == IDX_LAST) begin
                            byte_idx_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= S_RESPOND;
                        end else begin
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                            state_q    <= S_IDLE;
                        end
                    end
                end
                S_RESPOND: begin
                    tmr_q    <= '0;
                    tx_idx_q <= '0;
                    txd_q    <= 1'b0;
                    state_q  <= S_TX_START;
                end
                S_TX_START: begin
                    if (tmr_q == TMR_LAST) begin
                        tmr_q      <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= tx_byte_c[0];
                        tx_shift_q <= {1'b1, tx_byte_c[7:1]};
                        state_q    <= S_TX_DATA;
                    end
                end
                S_TX_DATA: begin
                    if (tmr_q == TMR_LAST) begin
                        tmr_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_TX_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[7:1]};
                        end
                    end
                end
                S_TX_STOP: begin
                    if (tmr_q == TMR_LAST) begin
                        tmr_q <= '0;
                        if (tx_idx_q == IDX_LAST) begin
                            busy_q      <= 1'b0;
                            pkt_count_q <= pkt_count_q + 16'd1;
                            state_q     <= S_IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_q + IDX_W'(1);
                            txd_q    <= 1'b0;
                            state_q  <= S_TX_START;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_echo_responder.sv
// Directed bench for packet_echo_responder (3-byte packets, 4 clocks per bit):
// a UART decoder on txd collects echoed bytes, each test checks them against hand values.
module tb_packet_echo_responder;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        txd, busy, frame_err;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] rxq [$];
    int ferr_cnt    = 0;
    int tx_stop_bad = 0;
    int busy_run    = 0;
    int busy_len    = 0;

    packet_echo_responder #(
        .PACKET_SIZE (3),
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .txd      (txd),
        .busy     (busy),
        .frame_err(frame_err),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Frame-error pulses and length of the most recent busy window
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    // UART receiver on txd, sampling each bit on its second cycle
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                repeat (5) @(negedge clk);
                b[0] = txd;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                if (txd !== 1'b1) tx_stop_bad++;
                rxq.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // Waits for a busy window to open and close; ok=0 if either bound expires
    task automatic wait_echo(output bit ok);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (n < 40 && busy !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        seen = (busy === 1'b1);
        n = 0;
        while (n < 400 && busy === 1'b1) begin
            @(negedge clk);
            n++;
        end
        ok = seen && (busy === 1'b0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt: got %0d expected 0", pkt_count); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_echo();
        logic [7:0] exp [3];
        bit ok;
        int f0;
        exp = '{8'h41, 8'h42, 8'h43};
        rxq.delete();
        f0 = ferr_cnt;
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        wait_echo(ok);
        total++; if (!ok) begin bad++; $display("FAIL echo_timeout: got busy=%b expected a complete busy window", busy); end
        total++; if (rxq.size() != 3) begin bad++; $display("FAIL echo_len: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                bad++; $display("FAIL echo_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (busy_len != 121) begin bad++; $display("FAIL echo_busy_len: got %0d expected 121", busy_len); end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL echo_pkt: got %0d expected 1", pkt_count); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL echo_ferr: got %0d expected %0d", ferr_cnt, f0); end
        total++; if (tx_stop_bad != 0) begin bad++; $display("FAIL echo_stopbit: got %0d expected 0", tx_stop_bad); end
    endtask

    task automatic test_frame_err();
        logic [7:0] exp [3];
        bit ok;
        int f0;
        exp = '{8'h01, 8'h02, 8'h03};
        rxq.delete();
        f0 = ferr_cnt;
        send_byte(8'h41, 1'b1);
        send_byte(8'h99, 1'b0);
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total++; if (ferr_cnt != f0 + 1) begin bad++; $display("FAIL ferr_pulse: got %0d expected %0d", ferr_cnt, f0 + 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b expected 0", busy); end
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        wait_echo(ok);
        total++; if (!ok) begin bad++; $display("FAIL ferr_timeout: got busy=%b expected a complete busy window", busy); end
        total++; if (rxq.size() != 3) begin bad++; $display("FAIL ferr_echo_len: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                bad++; $display("FAIL ferr_echo_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL ferr_pkt: got %0d expected 2", pkt_count); end
    endtask

    task automatic test_glitch();
        int f0;
        int lows;
        rxq.delete();
        f0 = ferr_cnt;
        lows = 0;
        rxd = 1'b0;
        @(posedge clk);
        #1;
        rxd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL glitch_txd: got %0d low cycles expected 0", lows); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
        total++; if (rxq.size() != 0) begin bad++; $display("FAIL glitch_rx: got %0d bytes expected 0", rxq.size()); end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL glitch_pkt: got %0d expected 2", pkt_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gap();
        logic [7:0] exp [3];
        bit ok;
        int f0;
        exp = '{8'h10, 8'h20, 8'h30};
        rxq.delete();
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (81) @(posedge clk);
        #1;
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        wait_echo(ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_timeout: got busy=%b expected a complete busy window", busy); end
        total++; if (rxq.size() != 3) begin bad++; $display("FAIL gap_echo_len: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                bad++; $display("FAIL gap_echo_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (pkt_count !== 16'd3) begin bad++; $display("FAIL gap_pkt: got %0d expected 3", pkt_count); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL gap_ferr: got %0d expected %0d", ferr_cnt, f0); end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp [3];
        bit ok;
        int n;
        int f0;
        exp = '{8'hFF, 8'h00, 8'h7E};
        rxq.delete();
        f0 = ferr_cnt;
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        n = 0;
        while (n < 40 && busy !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy_rise: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        // Toggle rxd for most of the echo, releasing it well before busy falls
        for (int k = 0; k < 33; k++) begin
            rxd = ~rxd;
            repeat (3) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        wait_echo(ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_timeout: got busy=%b expected busy to fall", busy); end
        total++; if (rxq.size() != 3) begin bad++; $display("FAIL ign_echo_len: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                bad++; $display("FAIL ign_echo_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (pkt_count !== 16'd4) begin bad++; $display("FAIL ign_pkt: got %0d expected 4", pkt_count); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL ign_ferr: got %0d expected %0d", ferr_cnt, f0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        bit ok;
        exp = '{8'h11, 8'h22, 8'h33};
        rxq.delete();
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        wait_echo(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got busy=%b expected a complete busy window", busy); end
        total++; if (rxq.size() != 3) begin bad++; $display("FAIL b2b_echo_len: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                bad++; $display("FAIL b2b_echo_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (pkt_count !== 16'd5) begin bad++; $display("FAIL b2b_pkt: got %0d expected 5", pkt_count); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] exp [3];
        bit ok;
        int n;
        int lows;
        exp = '{8'h5A, 8'hA5, 8'h3C};
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        n = 0;
        while (n < 40 && busy !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_rise: got %b expected 1", busy); end
        // Land inside the second echoed byte
        repeat (55) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL rst_mid_pkt: got %0d expected 0", pkt_count); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL rst_quiet_txd: got %0d low cycles expected 0", lows); end
        @(posedge clk);
        #1;
        rxq.delete();
        foreach (exp[i]) send_byte(exp[i], 1'b1);
        wait_echo(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_timeout: got busy=%b expected a complete busy window", busy); end
        total++; if (rxq.size() != 3) begin bad++; $display("FAIL rst_echo_len: got %0d expected 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rxq.size() || rxq[i] !== exp[i]) begin
                bad++; $display("FAIL rst_echo_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL rst_pkt: got %0d expected 1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_frame_err();
        test_glitch();
        test_gap();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
